// File: rtl/decimate_pkg.sv
// decimate_pkg: shared types and defaults for the decimating output buffer.
//   sample_t          16-bit sample word
//   DECIM_FACTOR_DEF  default decimation ratio
//   FIFO_DEPTH_DEF    default buffer depth (entries)
//   fifo_state_e      buffer occupancy state (EMPTY / ACTIVE / FULL)
package decimate_pkg;

  typedef logic [15:0] sample_t;

  localparam int unsigned DECIM_FACTOR_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF   = 8;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ACTIVE,
    FIFO_FULL
  } fifo_state_e;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: register-based FIFO holding decimated samples.
// Ports:
//   clk_i      clock (rising edge)
//   rst_i      asynchronous active-high reset; clears storage, pointers, count
//   wr_en_i    write request (accepted unless full without a same-cycle read)
//   wr_data_i  sample to write
//   rd_en_i    read request (ignored while empty)
//   rd_data_o  sample at the head, read straight from storage registers
//   full_o     occupancy == DEPTH
//   empty_o    occupancy == 0
//   count_o    current occupancy, 0..DEPTH
module sample_fifo
  import decimate_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  sample_t                  wr_data_i,
  input  logic                     rd_en_i,
  output sample_t                  rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  sample_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  fifo_state_e     state_q;
  fifo_state_e     state_d;
  logic            do_rd;
  logic            do_wr;

  // A write into a full buffer is accepted only when the head leaves on the same edge.
  always_comb begin
    do_rd   = rd_en_i && (state_q != FIFO_EMPTY);
    do_wr   = wr_en_i && ((state_q != FIFO_FULL) || do_rd);
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end
    state_d = FIFO_ACTIVE;
    if (count_d == '0) begin
      state_d = FIFO_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = FIFO_FULL;
    end
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= FIFO_EMPTY;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (state_q == FIFO_FULL);
  assign empty_o   = (state_q == FIFO_EMPTY);
  assign count_o   = count_q;

endmodule

// File: rtl/decimate_buffer.sv
// decimate_buffer: keeps one of every DECIM_FACTOR valid samples and queues
// the kept samples in a FIFO with a valid/ready output.
// Ports:
//   clk       clock (rising edge)
//   reset     asynchronous active-high reset
//   y         16-bit input sample
//   y_valid   y carries a new sample this cycle
//   m_data    sample at buffer head (registered)
//   m_valid   buffer non-empty
//   m_ready   consumer takes m_data this cycle
//   fill      buffer occupancy
//   overflow  sticky dropped-sample flag
// Build option: define DECIMATE_OVERFLOW_FLAG_EN to enable the sticky overflow
// flag; otherwise overflow is tied low and drops are silent.
module decimate_buffer
  import decimate_pkg::*;
#(
  parameter int unsigned DECIM_FACTOR = DECIM_FACTOR_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   y,
  input  logic                          y_valid,
  output logic [15:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow
);

  localparam int unsigned PHASE_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;

  always_comb begin
    phase_d = phase_q;
    if (y_valid) begin
      phase_d = (phase_q == PHASE_W'(DECIM_FACTOR - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  assign capture = y_valid && (phase_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (capture),
    .wr_data_i (y),
    .rd_en_i   (m_ready),
    .rd_data_o (m_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fill)
  );

  assign m_valid = !fifo_empty;

`ifdef DECIMATE_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Full implies non-empty, so a read happens exactly when m_ready is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (capture && fifo_full && !m_ready) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_full;
  assign unused_full = fifo_full;
  assign overflow    = 1'b0;
`endif

endmodule
